instr_encoder: RTL

//  Assembles 32-bit RV32I instruction words from discrete fields. This is the

---
 rtl/instr_encoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction word assembler: builds a word from discrete fields, flags illegal
// field combinations (substituting a NOP), and buffers results in a small valid/ready FIFO.
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [3:0]       out_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // ------------------------------------------------------------------
    // Field encoding and legality checks
    // ------------------------------------------------------------------
    logic [31:0] raw_instr;
    logic [31:0] enc_instr;
    logic [3:0]  enc_err;
    logic        fmt_bad;
    logic        op_bad;
    logic        imm_bad;
    logic        imm_odd;
    logic        op_low_ok;
    logic [4:0]  op_class;
    logic        fits_12;
    logic        fits_13;
    logic        fits_21;

    // An immediate fits N signed bits when everything above bit N-1 is its sign copy.
    assign fits_12 = (in_imm[31:11] == {21{in_imm[11]}});
    assign fits_13 = (in_imm[31:12] == {20{in_imm[12]}});
    assign fits_21 = (in_imm[31:20] == {12{in_imm[20]}});

    assign op_low_ok = (in_opcode[1:0] == 2'b11);
    assign op_class  = in_opcode[6:2];

    always_comb begin
        raw_instr = NOP_WORD;
        fmt_bad   = 1'b0;
        op_bad    = 1'b0;
        imm_bad   = 1'b0;
        imm_odd   = 1'b0;
        case (in_fmt)
            FMT_R: begin
                raw_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                op_bad    = !(op_low_ok &&
                              (op_class inside {5'b01011, 5'b01100, 5'b01110, 5'b10100}));
            end
            FMT_I: begin
                raw_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                op_bad    = !(op_low_ok &&
                              (op_class inside {5'b00000, 5'b00001, 5'b00100,
                                                5'b00110, 5'b11001}));
                imm_bad   = !fits_12;
            end
            FMT_S: begin
                raw_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                op_bad    = !(op_low_ok && (op_class inside {5'b01000, 5'b01001}));
                imm_bad   = !fits_12;
            end
            FMT_B: begin
                raw_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                op_bad    = !(op_low_ok && (op_class == 5'b11000));
                imm_bad   = !fits_13;
                imm_odd   = in_imm[0];
            end
            FMT_U: begin
                raw_instr = {in_imm[31:12], in_rd, in_opcode};
                op_bad    = !(op_low_ok && (op_class inside {5'b00101, 5'b01101}));
                imm_bad   = (in_imm[11:0] != 12'h000);
            end
            FMT_J: begin
                raw_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, in_opcode};
                op_bad    = !(op_low_ok && (op_class == 5'b11011));
                imm_bad   = !fits_21;
                imm_odd   = in_imm[0];
            end
            default: begin
                fmt_bad = 1'b1;
            end
        endcase
    end

    assign enc_err   = {imm_odd, imm_bad, op_bad, fmt_bad};
    assign enc_instr = (enc_err != 4'b0000) ? NOP_WORD : raw_instr;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [31:0]      entry_instr_q [DEPTH];
    logic [31:0]      entry_instr_d [DEPTH];
    logic [3:0]       entry_err_q   [DEPTH];
    logic [3:0]       entry_err_d   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Readiness depends on registered occupancy only; a full FIFO never accepts
    // even if the head is being popped in the same cycle.
    assign in_ready  = rst_n && (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_instr = out_valid ? entry_instr_q[rd_ptr_q] : '0;
    assign out_err   = out_valid ? entry_err_q[rd_ptr_q]   : '0;
    assign err_count = err_count_q;

    always_comb begin
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q;
        err_count_d = err_count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push && (enc_err != 4'b0000) && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            entry_instr_d[i] = entry_instr_q[i];
            entry_err_d[i]   = entry_err_q[i];
            if (push && (wr_ptr_q == PTR_W'(i))) begin
                entry_instr_d[i] = enc_instr;
                entry_err_d[i]   = enc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_instr_q[i] <= '0;
                entry_err_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_count_q <= err_count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_instr_q[i] <= entry_instr_d[i];
                entry_err_q[i]   <= entry_err_d[i];
            end
        end
    end

endmodule
